usb_rx_txn_ctrl: RTL and testbench

Transaction-level controller for the USB RX datapath. It consumes decoded packet events and data bytes from the receiver and sequences each OUT transaction. It tracks the DATA0/DATA1 toggle, writes payload bytes into the shared RX buffer with commit or rollback, and requests the ACK/NAK handshake from the TX path. It sits between the receiver and the AHB-Lite endpoint buffer.

---
 rtl/usb_rx_txn_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_usb_rx_txn_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_txn_ctrl.sv
// OUT-transaction sequencer for the USB RX path: data toggle tracking, RX buffer
// write/commit/rollback, and ACK/NAK handshake requests toward the TX path.
module usb_rx_txn_ctrl #(
  parameter int unsigned MAX_PKT        = 64,
  parameter int unsigned TIMEOUT_CYCLES = 144,
  localparam int unsigned CW            = $clog2(MAX_PKT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    rx_packet,
  input  logic          rx_packet_strobe,
  input  logic [7:0]    rx_packet_data,
  input  logic          store_rx_packet_data,
  input  logic [CW-1:0] buf_space,
  output logic          buf_wr_en,
  output logic [7:0]    buf_wr_data,
  output logic          buf_commit,
  output logic [CW-1:0] buf_commit_len,
  output logic          buf_rollback,
  output logic          tx_req,
  output logic          tx_hs,
  input  logic          tx_ack,
  input  logic          clear_toggle,
  output logic          exp_toggle,
  output logic          rx_busy,
  output logic          rx_data_ready,
  output logic          rx_error
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] PidOut   = 3'd1;
  localparam logic [2:0] PidData0 = 3'd3;
  localparam logic [2:0] PidData1 = 3'd4;
  localparam logic [2:0] EvEopOk  = 3'd7;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StWaitData = 3'd1;
  localparam logic [2:0] StRxData   = 3'd2;
  localparam logic [2:0] StDiscard  = 3'd3;
  localparam logic [2:0] StSendHs   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          tog_q, tog_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          wr_en_d, commit_d, rollback_d, req_d, hs_d, rdy_d, err_d;
  logic [7:0]    wr_data_d;
  logic [CW-1:0] len_d;

  logic          is_data, pid_bit, timed_out, accept, flip, ovf_n;
  logic [CW-1:0] cnt_n;

  assign is_data   = rx_packet_strobe && (rx_packet == PidData0 || rx_packet == PidData1);
  assign pid_bit   = (rx_packet == PidData1);
  assign timed_out = (timer_q >= TW'(TIMEOUT_CYCLES - 1));
  assign accept    = store_rx_packet_data && (cnt_q < buf_space) && (cnt_q < CW'(MAX_PKT));
  // A byte arriving with the EOP strobe is folded in before the EOP is judged.
  assign cnt_n     = cnt_q + {{(CW - 1){1'b0}}, accept};
  assign ovf_n     = ovf_q | (store_rx_packet_data & ~accept);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    timer_d    = timer_q;
    wr_en_d    = 1'b0;
    wr_data_d  = 8'h00;
    commit_d   = 1'b0;
    len_d      = '0;
    rollback_d = 1'b0;
    req_d      = tx_req;
    hs_d       = tx_hs;
    rdy_d      = 1'b0;
    err_d      = 1'b0;
    flip       = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_packet_strobe && rx_packet == PidOut) begin
          state_d = StWaitData;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          timer_d = '0;
        end
      end
      StWaitData: begin
        if (rx_packet_strobe) begin
          timer_d = '0;
          if (is_data) begin
            state_d = (pid_bit == tog_q) ? StRxData : StDiscard;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRxData: begin
        cnt_d = cnt_n;
        ovf_d = ovf_n;
        if (accept) begin
          wr_en_d   = 1'b1;
          wr_data_d = rx_packet_data;
        end
        if (rx_packet_strobe) begin
          timer_d = '0;
          if (rx_packet == EvEopOk) begin
            state_d = StSendHs;
            req_d   = 1'b1;
            if (!ovf_n) begin
              commit_d = 1'b1;
              len_d    = cnt_n;
              rdy_d    = 1'b1;
              flip     = 1'b1;
              hs_d     = 1'b0;
            end else begin
              rollback_d = 1'b1;
              hs_d       = 1'b1;
            end
          end else begin
            state_d    = StIdle;
            rollback_d = 1'b1;
            err_d      = 1'b1;
          end
        end else if (accept) begin
          timer_d = '0;
        end else if (timed_out) begin
          state_d    = StIdle;
          rollback_d = 1'b1;
          err_d      = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDiscard: begin
        if (rx_packet_strobe) begin
          timer_d = '0;
          if (rx_packet == EvEopOk) begin
            state_d = StSendHs;
            req_d   = 1'b1;
            hs_d    = 1'b0;
          end else begin
            state_d = StIdle;
            err_d   = 1'b1;
          end
        end else if (timed_out) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StSendHs: begin
        if (tx_ack) begin
          state_d = StIdle;
          req_d   = 1'b0;
          hs_d    = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    // Clearing the toggle overrides a flip from a commit in the same cycle.
    tog_d = clear_toggle ? 1'b0 : (tog_q ^ flip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      tog_q          <= 1'b0;
      cnt_q          <= '0;
      ovf_q          <= 1'b0;
      timer_q        <= '0;
      buf_wr_en      <= 1'b0;
      buf_wr_data    <= 8'h00;
      buf_commit     <= 1'b0;
      buf_commit_len <= '0;
      buf_rollback   <= 1'b0;
      tx_req         <= 1'b0;
      tx_hs          <= 1'b0;
      rx_data_ready  <= 1'b0;
      rx_error       <= 1'b0;
    end else begin
      state_q        <= state_d;
      tog_q          <= tog_d;
      cnt_q          <= cnt_d;
      ovf_q          <= ovf_d;
      timer_q        <= timer_d;
      buf_wr_en      <= wr_en_d;
      buf_wr_data    <= wr_data_d;
      buf_commit     <= commit_d;
      buf_commit_len <= len_d;
      buf_rollback   <= rollback_d;
      tx_req         <= req_d;
      tx_hs          <= hs_d;
      rx_data_ready  <= rdy_d;
      rx_error       <= err_d;
    end
  end

  assign exp_toggle = tog_q;
  assign rx_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_usb_rx_txn_ctrl.sv
// Directed cycle vectors plus hand-written timeout and max-packet sequences for
// usb_rx_txn_ctrl.
module tb_usb_rx_txn_ctrl;

  localparam int OUT = 1, IN = 2, D0 = 3, D1 = 4, ERR = 6, EOP = 7;

  typedef struct packed {
    logic       rst;
    logic [2:0] pkt;
    logic [7:0] din;
    logic       store;
    logic [6:0] sp;
    logic       ack;
    logic       clr;
  } in_t;

  typedef struct packed {
    logic       wr;
    logic [7:0] wd;
    logic       cm;
    logic [6:0] len;
    logic       rb;
    logic       rq;
    logic       hs;
    logic       tg;
    logic       bz;
    logic       rd;
    logic       er;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] rx_packet;
  logic       rx_packet_strobe;
  logic [7:0] rx_packet_data;
  logic       store_rx_packet_data;
  logic [6:0] buf_space;
  logic       buf_wr_en;
  logic [7:0] buf_wr_data;
  logic       buf_commit;
  logic [6:0] buf_commit_len;
  logic       buf_rollback;
  logic       tx_req;
  logic       tx_hs;
  logic       tx_ack;
  logic       clear_toggle;
  logic       exp_toggle;
  logic       rx_busy;
  logic       rx_data_ready;
  logic       rx_error;

  int   total = 0;
  int   passed = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  usb_rx_txn_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_packet           (rx_packet),
    .rx_packet_strobe    (rx_packet_strobe),
    .rx_packet_data      (rx_packet_data),
    .store_rx_packet_data(store_rx_packet_data),
    .buf_space           (buf_space),
    .buf_wr_en           (buf_wr_en),
    .buf_wr_data         (buf_wr_data),
    .buf_commit          (buf_commit),
    .buf_commit_len      (buf_commit_len),
    .buf_rollback        (buf_rollback),
    .tx_req              (tx_req),
    .tx_hs               (tx_hs),
    .tx_ack              (tx_ack),
    .clear_toggle        (clear_toggle),
    .exp_toggle          (exp_toggle),
    .rx_busy             (rx_busy),
    .rx_data_ready       (rx_data_ready),
    .rx_error            (rx_error)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic add(input int r, input int pkt, input int din, input int st, input int sp,
                     input int ack, input int clr, input int wr, input int wd, input int cm,
                     input int len, input int rb, input int rq, input int hs, input int tg,
                     input int bz, input int rd, input int er);
    vec_t v;
    v.i = '{rst: 1'(r), pkt: 3'(pkt), din: 8'(din), store: 1'(st), sp: 7'(sp), ack: 1'(ack),
            clr: 1'(clr)};
    v.o = '{wr: 1'(wr), wd: 8'(wd), cm: 1'(cm), len: 7'(len), rb: 1'(rb), rq: 1'(rq),
            hs: 1'(hs), tg: 1'(tg), bz: 1'(bz), rd: 1'(rd), er: 1'(er)};
    vecs.push_back(v);
  endtask

  task automatic drive(input int pkt, input int st, input int din);
    @(negedge clk);
    rst                  = 1'b0;
    rx_packet            = 3'(pkt);
    rx_packet_strobe     = (pkt != 0);
    store_rx_packet_data = 1'(st);
    rx_packet_data       = 8'(din);
    tx_ack               = 1'b0;
    clear_toggle         = 1'b0;
  endtask

  function automatic out_t sample();
    return {buf_wr_en, buf_wr_data, buf_commit, buf_commit_len, buf_rollback, tx_req, tx_hs,
            exp_toggle, rx_busy, rx_data_ready, rx_error};
  endfunction

  initial begin
    int   n_err, n_wr, early, req_seen;
    logic rb_seen;
    out_t act;
    rst = 1'b0; rx_packet = '0; rx_packet_strobe = 1'b0; rx_packet_data = '0;
    store_rx_packet_data = 1'b0; buf_space = 7'd64; tx_ack = 1'b0; clear_toggle = 1'b0;

    //  rst pkt din st sp ack clr | wr wd cm len rb rq hs tg bz rd er
    add(1, 0,   0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'hA1, 1, 64, 0, 0,  1, 'hA1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'hB2, 1, 64, 0, 0,  1, 'hB2, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'hC3, 1, 64, 0, 0,  1, 'hC3, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, EOP, 0,    0, 64, 0, 0,  0, 0,    1, 3, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0,   0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0,   0,    0, 64, 1, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0,   0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Toggle is 1: DATA0 is a retransmit, discarded but ACKed.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0,   'h11, 1, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0,   'h22, 1, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, EOP, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 1, 0, 1, 1, 0, 0);
    add(0, 0,   0,    0, 64, 1, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Buffer space 2: overflow gives rollback and NAK.
    add(0, 0,   0,    0, 64, 0, 1,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, OUT, 0,    0, 2,  0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 2,  0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'h01, 1, 2,  0, 0,  1, 'h01, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'h02, 1, 2,  0, 0,  1, 'h02, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'h03, 1, 2,  0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'h04, 1, 2,  0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, EOP, 0,    0, 2,  0, 0,  0, 0,    0, 0, 1, 1, 1, 0, 1, 0, 0);
    add(0, 0,   0,    0, 2,  1, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Five bytes then ERROR: rollback, error, no handshake.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++)
      add(0, 0, 'h10 + k, 1, 64, 0, 0, 1, 'h10 + k, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, ERR, 0,    0, 64, 0, 0,  0, 0,    0, 0, 1, 0, 0, 0, 0, 0, 1);
    add(0, 0,   0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Commit with clear_toggle in the same cycle: clear wins.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0,   'h5A, 1, 64, 0, 0,  1, 'h5A, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, EOP, 0,    0, 64, 0, 1,  0, 0,    1, 1, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0,   0,    0, 64, 1, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Byte together with EOP counts toward the commit length.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, EOP, 'h77, 1, 64, 0, 0,  1, 'h77, 1, 1, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0,   0,    0, 64, 1, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Reset inside RX_DATA: nothing issued, toggle back to 0.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, D1,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0,   'h99, 1, 64, 0, 0,  1, 'h99, 0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(1, EOP, 'hAA, 1, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0,   0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Zero-length packet commits len 0 and flips the toggle.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, D0,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, EOP, 0,    0, 64, 0, 0,  0, 0,    1, 0, 0, 1, 0, 1, 1, 1, 0);
    add(0, 0,   0,    0, 64, 1, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 0);
    // Non-data PID while waiting for data aborts.
    add(0, OUT, 0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, IN,  0,    0, 64, 0, 0,  0, 0,    0, 0, 0, 0, 0, 1, 0, 0, 1);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst                  = vecs[i].i.rst;
      rx_packet            = vecs[i].i.pkt;
      rx_packet_strobe     = (vecs[i].i.pkt != 3'd0);
      rx_packet_data       = vecs[i].i.din;
      store_rx_packet_data = vecs[i].i.store;
      buf_space            = vecs[i].i.sp;
      tx_ack               = vecs[i].i.ack;
      clear_toggle         = vecs[i].i.clr;
      @(posedge clk);
      #1;
      act = sample();
      chk($sformatf("vec%0d", i), 32'(act), 32'(vecs[i].o));
    end
    buf_space = 7'd64;

    // Silence after OUT: error exactly on the 144th clock.
    drive(OUT, 0, 0);
    drive(0, 0, 0);
    early = 0; req_seen = 0;
    for (int k = 1; k < 144; k++) begin
      @(posedge clk); #1;
      if (rx_error) early++;
      if (tx_req) req_seen++;
    end
    chk("wait_timeout_early", 32'(early), 32'd0);
    @(posedge clk); #1;
    chk("wait_timeout_err", 32'(rx_error), 32'd1);
    chk("wait_timeout_busy", 32'(rx_busy), 32'd0);
    chk("wait_timeout_noreq", 32'(req_seen + int'(tx_req)), 32'd0);

    // Timeout inside RX_DATA also rolls back; toggle is 1 here.
    drive(OUT, 0, 0);
    drive(D1, 0, 0);
    drive(0, 1, 'h42);
    drive(0, 0, 0);
    n_err = 0; rb_seen = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (rx_error) begin
        n_err   = k;
        rb_seen = buf_rollback;
        break;
      end
    end
    chk("data_timeout_cycle", 32'(n_err), 32'd144);
    chk("data_timeout_rollback", 32'(rb_seen), 32'd1);

    // 65 bytes with ample space: MAX_PKT caps writes at 64, then NAK.
    buf_space = 7'd100;
    drive(OUT, 0, 0);
    drive(D1, 0, 0);
    n_wr = 0;
    for (int k = 0; k < 65; k++) begin
      drive(0, 1, k);
      @(posedge clk); #1;
      if (buf_wr_en) n_wr++;
    end
    chk("maxpkt_writes", 32'(n_wr), 32'd64);
    drive(EOP, 0, 0);
    @(posedge clk); #1;
    chk("maxpkt_rollback", 32'(buf_rollback), 32'd1);
    chk("maxpkt_nocommit", 32'(buf_commit), 32'd0);
    chk("maxpkt_nak", 32'({tx_req, tx_hs}), 32'b11);
    drive(0, 0, 0);
    tx_ack = 1'b1;
    @(posedge clk); #1;
    chk("maxpkt_done", 32'({tx_req, rx_busy, exp_toggle}), 32'b001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
